keypad_scanner: RTL and testbench

- Scans a 4x4 matrix keypad and debounces it.
- Produces the keyboard index word that the memory-mapped IO block decodes:
  - bit 4 = key held (read at 0xffff_ff34).
  - bits 3:0 = key code (read at 0xffff_ff38).
- Sits between the board keypad pins and the memory/MMIO block, in the top-level IO layer.
- Code map: keys 0-9 give 0x0-0x9, A-D give 0xA-0xD, * gives 0xE, # gives 0xF.

---
 rtl/keypad_pkg.sv | 32 +++
 rtl/keypad_scanner_sync.sv | 31 +++
 rtl/keypad_scanner.sv | 143 ++++++++++++++
 tb/tb_keypad_scanner.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 keypad scanner.
//   - state_t  : scanner FSM states
//   - ROWS/COLS: keypad matrix geometry
//   - CODE_TBL : key code for each {row, col} position
// The keyboard index width normally comes from the project Const.svh;
// the fallback below only applies when that header was not read first.
`ifndef KBCODE_WID
`define KBCODE_WID 5
`endif

package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  // Layout: r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = * 0 # D
  // '*' encodes as 0xE and '#' as 0xF.
  localparam logic [3:0] CODE_TBL [ROWS*COLS] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

endpackage

// File: rtl/keypad_scanner_sync.sv
// sync2: generic two-flop synchronizer for asynchronous level inputs.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset; both stages reset to all ones
//             (matches idle pulled-up keypad columns)
//   i_d     : asynchronous input, WIDTH bits
//   o_q     : synchronized output, two i_clk cycles of latency
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans and debounces a 4x4 matrix keypad.
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   col_in      : keypad columns, active low, asynchronous to clk
//   row_out     : row drive, active low, exactly one row low
//   kb_idx      : {held, code[3:0]} keyboard index word for the MMIO block
//   press_pulse : one-cycle strobe per accepted press
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYC   = 16,     // min 4: covers the synchronizer delay
  parameter int DEBOUNCE_CYC = 200000  // min 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             col_in,
  output logic [3:0]             row_out,
  output logic [`KBCODE_WID-1:0] kb_idx,
  output logic                   press_pulse
);

  localparam int CNT_MAX = (SETTLE_CYC > DEBOUNCE_CYC) ? SETTLE_CYC : DEBOUNCE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYC - 1);

  logic [3:0]             w_col_s;
  state_t                 r_state, w_state_nxt;
  logic [1:0]             r_row, w_row_nxt, w_row_adv;
  logic [1:0]             r_cap_col, w_cap_col_nxt, w_low_col;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [`KBCODE_WID-1:0] r_kb_idx, w_kb_idx_nxt;
  logic                   r_press, w_press_nxt;
  logic [3:0]             r_row_out;
  logic                   w_any_low, w_key_low;

  sync2 #(.WIDTH(4)) u_col_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (col_in),
    .o_q     (w_col_s)
  );

  assign w_row_adv = r_row + 2'd1;
  assign w_any_low = ~&w_col_s;
  assign w_key_low = ~w_col_s[r_cap_col];

  // Lowest-index low column wins when several keys in a row are down.
  always_comb begin
    w_low_col = 2'd3;
    if (!w_col_s[0])      w_low_col = 2'd0;
    else if (!w_col_s[1]) w_low_col = 2'd1;
    else if (!w_col_s[2]) w_low_col = 2'd2;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_row_nxt     = r_row;
    w_cap_col_nxt = r_cap_col;
    w_cnt_nxt     = r_cnt;
    w_kb_idx_nxt  = r_kb_idx;
    w_press_nxt   = 1'b0;
    case (r_state)
      SCAN: begin
        if (r_cnt == SETTLE_LAST) begin
          w_cnt_nxt = '0;
          if (w_any_low) begin
            w_cap_col_nxt = w_low_col;
            w_state_nxt   = DEBOUNCE;
          end else begin
            w_row_nxt = w_row_adv;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (!w_key_low) begin
          w_state_nxt = SCAN;
          w_row_nxt   = w_row_adv;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt  = PRESSED;
          w_cnt_nxt    = '0;
          w_kb_idx_nxt = {1'b1, CODE_TBL[{r_row, r_cap_col}]};
          w_press_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      PRESSED: begin
        // Only the captured column matters; other keys are ignored.
        if (!w_key_low) begin
          w_state_nxt = RELEASE;
          w_cnt_nxt   = '0;
        end
      end
      RELEASE: begin
        if (w_key_low) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt     = SCAN;
          w_row_nxt       = w_row_adv;
          w_cnt_nxt       = '0;
          w_kb_idx_nxt[4] = 1'b0;  // code bits keep the last key
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = SCAN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= SCAN;
      r_row     <= 2'd0;
      r_cap_col <= 2'd0;
      r_cnt     <= '0;
      r_kb_idx  <= '0;
      r_press   <= 1'b0;
      r_row_out <= 4'b1110;
    end else begin
      r_state   <= w_state_nxt;
      r_row     <= w_row_nxt;
      r_cap_col <= w_cap_col_nxt;
      r_cnt     <= w_cnt_nxt;
      r_kb_idx  <= w_kb_idx_nxt;
      r_press   <= w_press_nxt;
      // Decoded from the next row index so the pins move with r_row.
      r_row_out <= ~(4'b0001 << w_row_nxt);
    end
  end

  assign row_out     = r_row_out;
  assign kb_idx      = r_kb_idx;
  assign press_pulse = r_press;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with a keypad model
// (SETTLE_CYC=4, DEBOUNCE_CYC=8).
module tb_keypad_scanner;

  logic        clk;
  logic        rst_n;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [4:0]  kb_idx;
  logic        press_pulse;
  logic [15:0] key_down;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;
  int p0;

  keypad_scanner #(
    .SETTLE_CYC   (4),
    .DEBOUNCE_CYC (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .col_in      (col_in),
    .row_out     (row_out),
    .kb_idx      (kb_idx),
    .press_pulse (press_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Keypad matrix: a pressed key (r,c) pulls column c low while row r is driven.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_down[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
  end

  // Counts clock cycles during which press_pulse is high.
  always @(posedge clk) begin
    if (press_pulse) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_kb(input string tag, input logic [4:0] exp, input int max_cyc);
    int n;
    n = 0;
    while (kb_idx !== exp && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(kb_idx), 32'(exp));
  endtask

  initial begin
    logic [3:0] exp_row;
    rst_n    = 1'b0;
    key_down = 16'h0000;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_row", 32'(row_out), 32'h0000000E);
    check("rst_kb", 32'(kb_idx), 32'h0);
    check("rst_pulse", 32'(press_pulse), 32'h0);

    // Idle scan: each row is driven for 4 cycles
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      exp_row = ~(4'b0001 << ((k / 4) % 4));
      check("scan_row", 32'(row_out), 32'(exp_row));
    end

    // Press "5" (r1,c1) and hold for about 100 cycles
    p0 = pulse_cnt;
    key_down[5] = 1'b1;
    wait_kb("press5_kb", 5'h15, 45);
    check("press5_row", 32'(row_out), 32'hD);
    repeat (2) @(negedge clk);
    check("press5_pulse", 32'(pulse_cnt - p0), 32'd1);
    repeat (95) @(negedge clk);
    check("hold5_kb", 32'(kb_idx), 32'h15);
    check("hold5_row", 32'(row_out), 32'hD);
    check("hold5_pulse", 32'(pulse_cnt - p0), 32'd1);

    // Release "5": sync (2) + PRESSED->RELEASE (1) + 8 release cycles
    key_down[5] = 1'b0;
    repeat (10) @(negedge clk);
    check("rel5_early", 32'(kb_idx), 32'h15);
    @(negedge clk);
    check("rel5_kb", 32'(kb_idx), 32'h05);

    // Bouncing "#" (r3,c2): never low long enough to be accepted
    p0 = pulse_cnt;
    for (int i = 0; i < 10; i++) begin
      key_down[14] = ~key_down[14];
      repeat (3) @(negedge clk);
    end
    check("bounce_pulse", 32'(pulse_cnt - p0), 32'd0);
    check("bounce_kb", 32'(kb_idx), 32'h05);
    key_down[14] = 1'b1;
    wait_kb("hash_kb", 5'h1F, 45);
    repeat (2) @(negedge clk);
    check("hash_pulse", 32'(pulse_cnt - p0), 32'd1);
    key_down[14] = 1'b0;
    wait_kb("hash_rel", 5'h0F, 20);

    // "A" (r0,c3) with glitchy release
    p0 = pulse_cnt;
    key_down[3] = 1'b1;
    wait_kb("a_kb", 5'h1A, 45);
    repeat (2) @(negedge clk);
    check("a_pulse", 32'(pulse_cnt - p0), 32'd1);
    for (int i = 0; i < 3; i++) begin
      key_down[3] = 1'b0;
      repeat (5) @(negedge clk);
      key_down[3] = 1'b1;
      repeat (2) @(negedge clk);
    end
    check("a_glitch_held", 32'(kb_idx[4]), 32'h1);
    check("a_glitch_kb", 32'(kb_idx), 32'h1A);
    check("a_glitch_pulse", 32'(pulse_cnt - p0), 32'd1);
    key_down[3] = 1'b0;
    wait_kb("a_rel", 5'h0A, 20);

    // "7" and "9" together, then "D" while 7 is held
    p0 = pulse_cnt;
    key_down[8]  = 1'b1;
    key_down[10] = 1'b1;
    wait_kb("sim_kb", 5'h17, 45);
    repeat (2) @(negedge clk);
    check("sim_pulse", 32'(pulse_cnt - p0), 32'd1);
    key_down[15] = 1'b1;
    repeat (40) @(negedge clk);
    check("sim_d_kb", 32'(kb_idx), 32'h17);
    check("sim_d_row", 32'(row_out), 32'hB);
    check("sim_d_pulse", 32'(pulse_cnt - p0), 32'd1);
    key_down = 16'h0000;
    wait_kb("sim_rel", 5'h07, 20);

    // Reset while "0" (r3,c1) is held, then re-detection
    key_down[13] = 1'b1;
    wait_kb("zero_kb", 5'h10, 45);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_kb", 32'(kb_idx), 32'h0);
    check("mid_rst_row", 32'(row_out), 32'hE);
    check("mid_rst_pulse", 32'(press_pulse), 32'h0);
    repeat (2) @(negedge clk);
    p0 = pulse_cnt;
    rst_n = 1'b1;
    wait_kb("zero_redet", 5'h10, 45);
    repeat (2) @(negedge clk);
    check("zero_redet_pulse", 32'(pulse_cnt - p0), 32'd1);
    key_down[13] = 1'b0;
    wait_kb("zero_rel", 5'h00, 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
